// File: rtl/game_score_tracker_if.sv
// game_score_tracker_if
// Groups the sample stream from the upstream counter with the scoring
// outputs of the tracker.
//   count_in/count_valid : counter value and "new sample" strobe
//   INIT                 : synchronous game restart
//   WINNER/LOSER         : one-cycle scoring pulses
//   GAMEOVER/WHO         : end-of-game level and which side hit the limit
//   win_count/lose_count : per-game score counters
// Modports: master drives the samples, slave is the tracker.
interface game_score_tracker_if #(
    parameter int COUNT_W = 3
);
    logic [COUNT_W-1:0] count_in;
    logic               count_valid;
    logic               INIT;
    logic               WINNER;
    logic               LOSER;
    logic               GAMEOVER;
    logic [1:0]         WHO;
    logic [3:0]         win_count;
    logic [3:0]         lose_count;

    modport master (
        output count_in, count_valid, INIT,
        input  WINNER, LOSER, GAMEOVER, WHO, win_count, lose_count
    );

    modport slave (
        input  count_in, count_valid, INIT,
        output WINNER, LOSER, GAMEOVER, WHO, win_count, lose_count
    );
endinterface

// File: rtl/game_score_tracker.sv
// game_score_tracker
// Watches an upstream counter and scores each time it enters its all-ones
// value (winner side) or zero (loser side). Once either side reaches
// SCORE_LIMIT the game is over and samples are ignored until INIT or reset.
// Ports:
//   clk : single clock, rising edge
//   rst : asynchronous active-low reset
//   bus : game_score_tracker_if slave modport (samples in, scores out)
module game_score_tracker #(
    parameter int COUNT_W     = 3,
    parameter int SCORE_LIMIT = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    game_score_tracker_if.slave  bus
);

    typedef enum logic {
        PLAY,
        OVER
    } state_t;

    localparam logic [COUNT_W-1:0] MAX_VAL = '1;
    localparam logic [COUNT_W-1:0] MIN_VAL = '0;
    localparam logic [3:0]         LIMIT   = 4'(SCORE_LIMIT);

    state_t             state;
    logic [COUNT_W-1:0] prev;
    logic               prev_ok;
    logic               winner_q;
    logic               loser_q;
    logic               gameover_q;
    logic [1:0]         who_q;
    logic [3:0]         win_q;
    logic [3:0]         lose_q;

    logic accept;
    logic max_entry;
    logic zero_entry;

    // An edge into an extreme only counts when the previous sample is known
    // and was not already at that extreme; prev_ok=0 means "unknown".
    assign accept     = (state == PLAY) && bus.count_valid && !bus.INIT;
    assign max_entry  = accept && (bus.count_in == MAX_VAL) &&
                        (!prev_ok || (prev != MAX_VAL));
    assign zero_entry = accept && (bus.count_in == MIN_VAL) &&
                        (!prev_ok || (prev != MIN_VAL));

    // Single FSM block; all outputs are registered so pulses and count
    // updates appear one cycle after the sampling edge. INIT has priority
    // over any sample in the same cycle. The < LIMIT guards keep the counters
    // from ever passing the limit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= PLAY;
            prev       <= '0;
            prev_ok    <= 1'b0;
            winner_q   <= 1'b0;
            loser_q    <= 1'b0;
            gameover_q <= 1'b0;
            who_q      <= 2'b00;
            win_q      <= 4'd0;
            lose_q     <= 4'd0;
        end else begin
            winner_q <= 1'b0;
            loser_q  <= 1'b0;
            if (bus.INIT) begin
                state      <= PLAY;
                prev_ok    <= 1'b0;
                gameover_q <= 1'b0;
                who_q      <= 2'b00;
                win_q      <= 4'd0;
                lose_q     <= 4'd0;
            end else begin
                case (state)
                    PLAY: begin
                        if (accept) begin
                            prev    <= bus.count_in;
                            prev_ok <= 1'b1;
                        end
                        if (max_entry && (win_q < LIMIT)) begin
                            winner_q <= 1'b1;
                            win_q    <= win_q + 4'd1;
                            if (win_q + 4'd1 == LIMIT) begin
                                state      <= OVER;
                                gameover_q <= 1'b1;
                                who_q      <= 2'b10;
                            end
                        end
                        if (zero_entry && (lose_q < LIMIT)) begin
                            loser_q <= 1'b1;
                            lose_q  <= lose_q + 4'd1;
                            if (lose_q + 4'd1 == LIMIT) begin
                                state      <= OVER;
                                gameover_q <= 1'b1;
                                who_q      <= 2'b01;
                            end
                        end
                    end
                    OVER: begin
                        // Everything holds until INIT or reset.
                    end
                    default: state <= PLAY;
                endcase
            end
        end
    end

    assign bus.WINNER     = winner_q;
    assign bus.LOSER      = loser_q;
    assign bus.GAMEOVER   = gameover_q;
    assign bus.WHO        = who_q;
    assign bus.win_count  = win_q;
    assign bus.lose_count = lose_q;

endmodule

// File: tb/tb_game_score_tracker.sv
// tb_game_score_tracker
// Directed table-driven bench for game_score_tracker. Two instances share
// clock and reset: dutA uses the default limit of 15, dutB a limit of 3 so
// the end-of-game paths are reachable in a few samples.
module tb_game_score_tracker;

    typedef struct {
        logic       sel;      // 0 = dutA, 1 = dutB
        logic       valid;
        logic       init;
        logic [2:0] cnt;
        logic       expW;
        logic       expL;
        logic       expGo;
        logic [1:0] expWho;
        logic [3:0] expWc;
        logic [3:0] expLc;
    } vec_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    vec_t vecs[$];

    game_score_tracker_if #(.COUNT_W(3)) busA ();
    game_score_tracker_if #(.COUNT_W(3)) busB ();

    game_score_tracker #(.COUNT_W(3), .SCORE_LIMIT(15)) dutA (
        .clk (clk),
        .rst (rst),
        .bus (busA.slave)
    );

    game_score_tracker #(.COUNT_W(3), .SCORE_LIMIT(3)) dutB (
        .clk (clk),
        .rst (rst),
        .bus (busB.slave)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic checkAll(input string tag, input logic sel, input logic w, input logic l,
                            input logic go, input logic [1:0] who,
                            input logic [3:0] wc, input logic [3:0] lc);
        if (!sel) begin
            checkOutput({tag, " A.WINNER"},   8'(busA.WINNER),     8'(w));
            checkOutput({tag, " A.LOSER"},    8'(busA.LOSER),      8'(l));
            checkOutput({tag, " A.GAMEOVER"}, 8'(busA.GAMEOVER),   8'(go));
            checkOutput({tag, " A.WHO"},      8'(busA.WHO),        8'(who));
            checkOutput({tag, " A.win"},      8'(busA.win_count),  8'(wc));
            checkOutput({tag, " A.lose"},     8'(busA.lose_count), 8'(lc));
        end else begin
            checkOutput({tag, " B.WINNER"},   8'(busB.WINNER),     8'(w));
            checkOutput({tag, " B.LOSER"},    8'(busB.LOSER),      8'(l));
            checkOutput({tag, " B.GAMEOVER"}, 8'(busB.GAMEOVER),   8'(go));
            checkOutput({tag, " B.WHO"},      8'(busB.WHO),        8'(who));
            checkOutput({tag, " B.win"},      8'(busB.win_count),  8'(wc));
            checkOutput({tag, " B.lose"},     8'(busB.lose_count), 8'(lc));
        end
    endtask

    task automatic addVec(input logic sel, input logic valid, input logic init, input logic [2:0] cnt,
                          input logic w, input logic l, input logic go, input logic [1:0] who,
                          input logic [3:0] wc, input logic [3:0] lc);
        vec_t v;
        v.sel = sel; v.valid = valid; v.init = init; v.cnt = cnt;
        v.expW = w; v.expL = l; v.expGo = go; v.expWho = who; v.expWc = wc; v.expLc = lc;
        vecs.push_back(v);
    endtask

    task automatic idleInputs();
        busA.count_valid = 1'b0; busA.INIT = 1'b0; busA.count_in = 3'd0;
        busB.count_valid = 1'b0; busB.INIT = 1'b0; busB.count_in = 3'd0;
    endtask

    // Drive one sample on the selected instance at the falling edge, then
    // check its outputs just after the following rising edge.
    task automatic applyStimulus(input vec_t v, input int idx);
        @(negedge clk);
        idleInputs();
        if (!v.sel) begin
            busA.count_valid = v.valid; busA.INIT = v.init; busA.count_in = v.cnt;
        end else begin
            busB.count_valid = v.valid; busB.INIT = v.init; busB.count_in = v.cnt;
        end
        @(posedge clk);
        #1;
        checkAll($sformatf("vec%0d", idx), v.sel, v.expW, v.expL, v.expGo, v.expWho, v.expWc, v.expLc);
    endtask

    task automatic sampleA(input logic [2:0] cnt);
        @(negedge clk);
        idleInputs();
        busA.count_valid = 1'b1;
        busA.count_in    = cnt;
    endtask

    task automatic doReset();
        @(negedge clk);
        idleInputs();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        idleInputs();

        // dutA, limit 15: first sample 0 scores, then 3,7,7,7,5,7.
        addVec(0, 1, 0, 3'd0, 0, 1, 0, 2'b00, 4'd0, 4'd1);
        addVec(0, 1, 0, 3'd3, 0, 0, 0, 2'b00, 4'd0, 4'd1);
        addVec(0, 1, 0, 3'd7, 1, 0, 0, 2'b00, 4'd1, 4'd1);
        addVec(0, 1, 0, 3'd7, 0, 0, 0, 2'b00, 4'd1, 4'd1);
        addVec(0, 1, 0, 3'd7, 0, 0, 0, 2'b00, 4'd1, 4'd1);
        addVec(0, 1, 0, 3'd5, 0, 0, 0, 2'b00, 4'd1, 4'd1);
        addVec(0, 1, 0, 3'd7, 1, 0, 0, 2'b00, 4'd2, 4'd1);
        addVec(0, 0, 0, 3'd0, 0, 0, 0, 2'b00, 4'd2, 4'd1);
        addVec(0, 1, 0, 3'd0, 0, 1, 0, 2'b00, 4'd2, 4'd2);
        addVec(0, 1, 0, 3'd0, 0, 0, 0, 2'b00, 4'd2, 4'd2);
        addVec(0, 1, 0, 3'd4, 0, 0, 0, 2'b00, 4'd2, 4'd2);
        addVec(0, 1, 0, 3'd0, 0, 1, 0, 2'b00, 4'd2, 4'd3);
        addVec(0, 1, 0, 3'd7, 1, 0, 0, 2'b00, 4'd3, 4'd3);
        // INIT with a sample: sample dropped, prev_ok cleared so 7 scores again.
        addVec(0, 1, 1, 3'd0, 0, 0, 0, 2'b00, 4'd0, 4'd0);
        addVec(0, 1, 0, 3'd7, 1, 0, 0, 2'b00, 4'd1, 4'd0);

        // dutB, limit 3: winner reaches limit, later samples ignored.
        addVec(1, 1, 0, 3'd7, 1, 0, 0, 2'b00, 4'd1, 4'd0);
        addVec(1, 1, 0, 3'd4, 0, 0, 0, 2'b00, 4'd1, 4'd0);
        addVec(1, 1, 0, 3'd7, 1, 0, 0, 2'b00, 4'd2, 4'd0);
        addVec(1, 1, 0, 3'd4, 0, 0, 0, 2'b00, 4'd2, 4'd0);
        addVec(1, 1, 0, 3'd7, 1, 0, 1, 2'b10, 4'd3, 4'd0);
        addVec(1, 1, 0, 3'd0, 0, 0, 1, 2'b10, 4'd3, 4'd0);
        addVec(1, 1, 0, 3'd7, 0, 0, 1, 2'b10, 4'd3, 4'd0);
        addVec(1, 0, 1, 3'd0, 0, 0, 0, 2'b00, 4'd0, 4'd0);
        // Build lose=2 then finish via winner, then INIT with a valid 0.
        addVec(1, 1, 0, 3'd0, 0, 1, 0, 2'b00, 4'd0, 4'd1);
        addVec(1, 1, 0, 3'd4, 0, 0, 0, 2'b00, 4'd0, 4'd1);
        addVec(1, 1, 0, 3'd0, 0, 1, 0, 2'b00, 4'd0, 4'd2);
        addVec(1, 1, 0, 3'd7, 1, 0, 0, 2'b00, 4'd1, 4'd2);
        addVec(1, 1, 0, 3'd4, 0, 0, 0, 2'b00, 4'd1, 4'd2);
        addVec(1, 1, 0, 3'd7, 1, 0, 0, 2'b00, 4'd2, 4'd2);
        addVec(1, 1, 0, 3'd4, 0, 0, 0, 2'b00, 4'd2, 4'd2);
        addVec(1, 1, 0, 3'd7, 1, 0, 1, 2'b10, 4'd3, 4'd2);
        addVec(1, 1, 1, 3'd0, 0, 0, 0, 2'b00, 4'd0, 4'd0);
        addVec(1, 1, 0, 3'd0, 0, 1, 0, 2'b00, 4'd0, 4'd1);
        // Loser reaches limit.
        addVec(1, 1, 0, 3'd4, 0, 0, 0, 2'b00, 4'd0, 4'd1);
        addVec(1, 1, 0, 3'd0, 0, 1, 0, 2'b00, 4'd0, 4'd2);
        addVec(1, 1, 0, 3'd4, 0, 0, 0, 2'b00, 4'd0, 4'd2);
        addVec(1, 1, 0, 3'd0, 0, 1, 1, 2'b01, 4'd0, 4'd3);
        addVec(1, 1, 0, 3'd7, 0, 0, 1, 2'b01, 4'd0, 4'd3);
        addVec(1, 1, 0, 3'd4, 0, 0, 1, 2'b01, 4'd0, 4'd3);
        addVec(1, 1, 0, 3'd0, 0, 0, 1, 2'b01, 4'd0, 4'd3);

        doReset();
        #1;
        checkAll("reset", 0, 0, 0, 0, 2'b00, 4'd0, 4'd0);
        checkAll("reset", 1, 0, 0, 0, 2'b00, 4'd0, 4'd0);

        foreach (vecs[i]) applyStimulus(vecs[i], i);

        // Asynchronous reset mid-game with win_count=5 on dutA.
        doReset();
        for (int i = 0; i < 5; i++) begin
            sampleA(3'd7);
            sampleA(3'd4);
        end
        @(negedge clk);
        idleInputs();
        #1;
        checkAll("pre-async", 0, 0, 0, 0, 2'b00, 4'd5, 4'd0);
        // Pull reset low between edges: outputs must clear before any edge.
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        checkAll("async-rst", 0, 0, 0, 0, 2'b00, 4'd0, 4'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkAll("post-rel", 0, 0, 0, 0, 2'b00, 4'd0, 4'd0);
        sampleA(3'd7);
        @(posedge clk);
        #1;
        checkAll("first7", 0, 1, 0, 0, 2'b00, 4'd1, 4'd0);
        @(negedge clk);
        idleInputs();
        @(posedge clk);
        #1;
        checkAll("pulse-end", 0, 0, 0, 0, 2'b00, 4'd1, 4'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog so the bench always ends even if something stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
